// File: rtl/keypad_matrix_responder_pkg.sv
// Shared definitions for the keypad matrix responder: FSM encoding, key_code
// field positions, idle row level and bounce LFSR constants.
package kp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_BOUNCE_P = 3'd1,
        ST_PRESS    = 3'd2,
        ST_BOUNCE_R = 3'd3,
        ST_GAP      = 3'd4
    } kp_state_e;

    localparam int KC_ROW_LSB = 2;
    localparam int KC_COL_LSB = 0;

    localparam logic [3:0] ROWS_IDLE = 4'hF;

    // Fibonacci taps 8,6,5,4 map to state bits 7,5,4,3
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // Counter reload value for an N-cycle phase; N=0 behaves as N=1
    function automatic int cnt_load(input int n);
        return (n < 1) ? 0 : n - 1;
    endfunction

endpackage

// File: rtl/keypad_matrix_responder_lfsr8.sv
// 8-bit Fibonacci LFSR driving contact chatter during bounce windows.
// Advances only while enabled; seeded at reset and never reseeded.
module kp_lfsr8
    import kp_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    output logic [7:0] o_state
);

    logic [7:0] r_state;
    logic       w_fb;

    assign w_fb = ^(r_state & LFSR_TAPS);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= LFSR_SEED;
        else if (i_en)
            r_state <= {r_state[6:0], w_fb};
    end

    assign o_state = r_state;

endmodule

// File: rtl/keypad_matrix_responder.sv
// Responder end of the 4x4 keypad matrix: emulates a pressed key against the
// scanner's column drive. Optional contact bounce under KEYPAD_BOUNCE_EN.
module keypad_matrix_responder
    import kp_pkg::*;
#(
    parameter int HOLD_CYCLES   = 1000,
    parameter int GAP_CYCLES    = 200,
    parameter int BOUNCE_CYCLES = 64,
    parameter int CNT_W         = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_code,
    input  logic       key_valid,
    output logic       key_ready,
    output logic       busy,
    output logic       key_done,
    input  logic [3:0] Keypad_cols,
    output logic [3:0] Keypad_rows
);

    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(cnt_load(HOLD_CYCLES));
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(cnt_load(GAP_CYCLES));

    if (cnt_load(HOLD_CYCLES) >= 2**CNT_W || cnt_load(GAP_CYCLES) >= 2**CNT_W ||
        cnt_load(BOUNCE_CYCLES) >= 2**CNT_W) begin : g_cnt_fit
        $error("keypad_matrix_responder: count parameter exceeds CNT_W");
    end

    kp_state_e        r_state, w_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [3:0]       r_code;
    logic [3:0]       r_rows;
    logic             w_accept;
    logic             w_cnt_zero;
    logic             w_contact;
    logic [1:0]       w_row, w_col;

`ifdef KEYPAD_BOUNCE_EN
    localparam logic [CNT_W-1:0] BNC_LD = CNT_W'(cnt_load(BOUNCE_CYCLES));
    logic       w_lfsr_en;
    logic [7:0] w_lfsr;

    kp_lfsr8 u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_lfsr_en),
        .o_state (w_lfsr)
    );

    assign w_lfsr_en = (r_state == ST_BOUNCE_P) || (r_state == ST_BOUNCE_R);
`endif

    assign w_accept   = key_valid && (r_state == ST_IDLE);
    assign w_cnt_zero = (r_cnt == '0);
    assign key_ready  = (r_state == ST_IDLE);
    assign busy       = (r_state != ST_IDLE);

    always_comb begin
        w_next    = r_state;
        w_cnt_nxt = w_cnt_zero ? r_cnt : r_cnt - 1'b1;
        w_contact = 1'b0;
        key_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
`ifdef KEYPAD_BOUNCE_EN
                    w_next    = ST_BOUNCE_P;
                    w_cnt_nxt = BNC_LD;
`else
                    w_next    = ST_PRESS;
                    w_cnt_nxt = HOLD_LD;
`endif
                end
            end
`ifdef KEYPAD_BOUNCE_EN
            ST_BOUNCE_P: begin
                w_contact = w_lfsr[0];
                if (w_cnt_zero) begin
                    w_next    = ST_PRESS;
                    w_cnt_nxt = HOLD_LD;
                end
            end
            ST_BOUNCE_R: begin
                w_contact = w_lfsr[0];
                if (w_cnt_zero) begin
                    w_next    = ST_GAP;
                    w_cnt_nxt = GAP_LD;
                end
            end
`endif
            ST_PRESS: begin
                w_contact = 1'b1;
                if (w_cnt_zero) begin
`ifdef KEYPAD_BOUNCE_EN
                    w_next    = ST_BOUNCE_R;
                    w_cnt_nxt = BNC_LD;
`else
                    w_next    = ST_GAP;
                    w_cnt_nxt = GAP_LD;
`endif
                end
            end
            ST_GAP: begin
                if (w_cnt_zero) begin
                    key_done = 1'b1;
                    w_next   = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_code  <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_nxt;
            if (w_accept)
                r_code <= key_code;
        end
    end

    assign w_row = r_code[KC_ROW_LSB +: 2];
    assign w_col = r_code[KC_COL_LSB +: 2];

    // Registered so the scanner sees rows one clock after it drives a column
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_rows <= ROWS_IDLE;
        else if (w_contact && !Keypad_cols[w_col])
            r_rows <= ROWS_IDLE & ~(4'b0001 << w_row);
        else
            r_rows <= ROWS_IDLE;
    end

    assign Keypad_rows = r_rows;

endmodule

// File: tb/tb_keypad_matrix_responder.sv
// Scoreboard bench for keypad_matrix_responder (default build, no bounce).
module tb_keypad_matrix_responder;

    localparam int H = 10;
    localparam int G = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] key_code = '0;
    logic       key_valid = 1'b0;
    logic       key_ready, busy, key_done;
    logic [3:0] Keypad_cols = 4'hF;
    logic [3:0] Keypad_rows;

    keypad_matrix_responder #(
        .HOLD_CYCLES   (H),
        .GAP_CYCLES    (G),
        .BOUNCE_CYCLES (8),
        .CNT_W         (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .busy        (busy),
        .key_done    (key_done),
        .Keypad_cols (Keypad_cols),
        .Keypad_rows (Keypad_rows)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [6:0] v;   // {rows, ready, busy, done}
    } exp_t;

    exp_t       q[$];
    int         n_chk = 0;
    int         n_pass = 0;
    int         m_since = -1;   // posedges since accept; -1 = idle
    logic [3:0] m_code = '0;
    int         m_acc = 0;
    int         d_acc = 0;
    logic [3:0] rot [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    always @(posedge clk)
        if (rst && key_valid && key_ready)
            d_acc++;

    // Drive one cycle, push the expected post-edge outputs, then pop and compare
    task automatic tick(input string tag, input logic v, input logic [3:0] code,
                        input logic [3:0] cols);
        logic       contact;
        logic [3:0] rows_e;
        exp_t       e;
        key_valid   = v;
        key_code    = code;
        Keypad_cols = cols;
        contact = (m_since >= 0) && (m_since < H);
        rows_e  = 4'hF;
        if (rst && contact && !cols[m_code[1:0]])
            rows_e[m_code[3:2]] = 1'b0;
        if (!rst)
            m_since = -1;
        else if (m_since < 0) begin
            if (v) begin
                m_since = 0;
                m_code  = code;
                m_acc++;
            end
        end else begin
            m_since++;
            if (m_since == H + G)
                m_since = -1;
        end
        e.tag = tag;
        e.v   = {rows_e, m_since < 0, m_since >= 0, m_since == H + G - 1};
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e = q.pop_front();
        chk(e.tag, {25'd0, Keypad_rows, key_ready, busy, key_done}, {25'd0, e.v});
    endtask

    initial begin
        @(negedge clk);
        for (int i = 0; i < 4; i++)
            tick("reset", 1'b1, 4'h5, rot[i]);
        rst = 1'b1;

        tick("single_acc", 1'b1, 4'b0110, 4'b1011);
        for (int i = 0; i < 19; i++)
            tick("single", 1'b0, 4'b0110, 4'b1011);

        tick("scan_acc", 1'b1, 4'b0110, rot[0]);
        for (int i = 0; i < 19; i++)
            tick("scan", 1'b0, 4'b0110, rot[(i + 1) % 4]);

        tick("b2b_first", 1'b1, 4'h0, 4'b0110);
        for (int i = 0; i < 40; i++)
            tick("b2b", 1'b1, 4'hF, 4'b0110);
        for (int i = 0; i < 20; i++)
            tick("b2b_drain", 1'b0, 4'hF, 4'b0110);

        tick("mid_acc", 1'b1, 4'b0110, 4'b1011);
        for (int i = 0; i < 3; i++)
            tick("mid_hold", 1'b0, 4'b0110, 4'b1011);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_rows", {28'd0, Keypad_rows}, 32'hF);
        chk("mid_rst_flags", {29'd0, key_ready, busy, key_done}, 32'b100);
        for (int i = 0; i < 2; i++)
            tick("mid_in_rst", 1'b1, 4'b0110, 4'b1011);
        rst = 1'b1;
        for (int i = 0; i < 2; i++)
            tick("post_rst_idle", 1'b0, 4'b0110, 4'b1011);

        tick("post_acc", 1'b1, 4'b1001, 4'b1101);
        for (int i = 0; i < 18; i++)
            tick("post", 1'b0, 4'b1001, 4'b1101);

        chk("accept_count", d_acc, m_acc);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
